// File: rtl/vending_machine_param_if.sv
// Vending controller bus: coin acceptor / keypad inputs and dispenser /
// coin-hopper outputs. The front end drives it through the master modport
// and the controller uses the slave modport.
// The sales_total signal exists only when VEND_SALES_CNT_EN is defined.
interface vending_machine_param_if #(
  parameter int OUT_W = 3,
  parameter int VAL_W = 8
);
  logic             coin_valid;
  logic [1:0]       coin_in_50;
  logic [1:0]       coin_in_10;
  logic [1:0]       coin_in_5;
  logic [1:0]       coin_in_1;
  logic [1:0]       item_req;
  logic             cancel;
  logic [OUT_W-1:0] coin_out_50;
  logic [OUT_W-1:0] coin_out_10;
  logic [OUT_W-1:0] coin_out_5;
  logic [OUT_W-1:0] coin_out_1;
  logic [1:0]       item_out;
  logic [1:0]       service_type;
  logic [VAL_W-1:0] credit;
  logic             done;
  logic             coin_reject;
  logic             short_fault;
`ifdef VEND_SALES_CNT_EN
  logic [15:0]      sales_total;
`endif

  modport master (
    output coin_valid, coin_in_50, coin_in_10, coin_in_5, coin_in_1,
    output item_req, cancel,
`ifdef VEND_SALES_CNT_EN
    input  sales_total,
`endif
    input  coin_out_50, coin_out_10, coin_out_5, coin_out_1,
    input  item_out, service_type, credit, done, coin_reject, short_fault
  );

  modport slave (
    input  coin_valid, coin_in_50, coin_in_10, coin_in_5, coin_in_1,
    input  item_req, cancel,
`ifdef VEND_SALES_CNT_EN
    output sales_total,
`endif
    output coin_out_50, coin_out_10, coin_out_5, coin_out_1,
    output item_out, service_type, credit, done, coin_reject, short_fault
  );
endinterface

// File: rtl/vending_machine_param.sv
// Parametrised vending controller. Credit accumulates from coin deposits,
// change is paid greedily one coin per cycle, and a failed change payout
// is rolled back into a full refund of the credit.
// Optional macro VEND_SALES_CNT_EN adds a 16-bit running sales total.
module vending_machine_param #(
  parameter int CNT_W    = 4,
  parameter int OUT_W    = 3,
  parameter int VAL_W    = 8,
  parameter int INIT_CNT = 2,
  parameter int COST_A   = 8,
  parameter int COST_B   = 15,
  parameter int COST_C   = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  vending_machine_param_if.slave vif
);
  localparam int SUM_W = VAL_W + 2;

  typedef enum logic [1:0] {S_ON, S_CHECK, S_PAY, S_OFF} state_t;
  typedef enum logic {PH_CHANGE, PH_REFUND} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [VAL_W-1:0] credit_q, credit_d;
  logic [VAL_W-1:0] target_q, target_d;
  logic [1:0]       item_q, item_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             reject_q, reject_d;
  logic             fault_q, fault_d;
  // Denomination index: 0 = 50, 1 = 10, 2 = 5, 3 = 1.
  logic [CNT_W-1:0] inv_q [4];
  logic [CNT_W-1:0] inv_d [4];
  logic [OUT_W-1:0] cout_q [4];
  logic [OUT_W-1:0] cout_d [4];
  logic [1:0]       cin [4];

  logic [SUM_W-1:0] dep_sum;
  logic [VAL_W-1:0] cred_eff;
  logic [VAL_W-1:0] cost;
  logic             pay_hit;
  logic [1:0]       pay_idx;

  function automatic logic [VAL_W-1:0] denom_val(input logic [1:0] idx);
    case (idx)
      2'd0:    return VAL_W'(50);
      2'd1:    return VAL_W'(10);
      2'd2:    return VAL_W'(5);
      default: return VAL_W'(1);
    endcase
  endfunction

  function automatic logic [VAL_W-1:0] item_cost(input logic [1:0] item);
    case (item)
      2'b01:   return VAL_W'(COST_A);
      2'b10:   return VAL_W'(COST_B);
      2'b11:   return VAL_W'(COST_C);
      default: return '0;
    endcase
  endfunction

  // Inventory counters saturate; coins beyond the maximum stay in the machine.
  function automatic logic [CNT_W-1:0] inv_sat_add(input logic [CNT_W-1:0] base,
                                                   input int add);
    int s;
    s = int'(base) + add;
    if (s > (2 ** CNT_W) - 1) return '1;
    return CNT_W'(s);
  endfunction

  assign cin[0] = vif.coin_in_50;
  assign cin[1] = vif.coin_in_10;
  assign cin[2] = vif.coin_in_5;
  assign cin[3] = vif.coin_in_1;

  // Next-state and datapath update for the ON / CHECK / PAY / OFF sequence.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    credit_d = credit_q;
    target_d = target_q;
    item_d   = item_q;
    ptr_d    = ptr_q;
    reject_d = 1'b0;
    fault_d  = fault_q;
    for (int i = 0; i < 4; i++) begin
      inv_d[i]  = inv_q[i];
      cout_d[i] = cout_q[i];
    end

    dep_sum = SUM_W'(credit_q)
            + SUM_W'(vif.coin_in_50) * SUM_W'(50)
            + SUM_W'(vif.coin_in_10) * SUM_W'(10)
            + SUM_W'(vif.coin_in_5)  * SUM_W'(5)
            + SUM_W'(vif.coin_in_1);
    cred_eff = credit_q;
    cost     = item_cost(item_q);

    // Greedy scan from the current pointer downward; skipping unpayable
    // denominations is folded into the same cycle as the payout.
    pay_hit = 1'b0;
    pay_idx = ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (!pay_hit && (2'(i) >= ptr_q) && (denom_val(2'(i)) <= target_q) &&
          (inv_q[i] != '0) && (cout_q[i] != '1)) begin
        pay_hit = 1'b1;
        pay_idx = 2'(i);
      end
    end

    case (state_q)
      S_ON: begin
        if (vif.coin_valid) begin
          if (dep_sum > SUM_W'((2 ** VAL_W) - 1)) begin
            reject_d = 1'b1;
          end else begin
            cred_eff = dep_sum[VAL_W-1:0];
            for (int i = 0; i < 4; i++) inv_d[i] = inv_sat_add(inv_q[i], int'(cin[i]));
          end
        end
        credit_d = cred_eff;
        // Cancel has priority over an item request; a zero-credit cancel is ignored.
        if (vif.cancel) begin
          if (cred_eff != '0) begin
            target_d = cred_eff;
            item_d   = 2'b00;
            phase_d  = PH_REFUND;
            ptr_d    = 2'd0;
            state_d  = S_PAY;
          end
        end else if (vif.item_req != 2'b00) begin
          item_d  = vif.item_req;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (credit_q < cost) begin
          target_d = credit_q;
          item_d   = 2'b00;
          phase_d  = PH_REFUND;
        end else begin
          target_d = credit_q - cost;
          phase_d  = PH_CHANGE;
        end
        for (int i = 0; i < 4; i++) cout_d[i] = '0;
        ptr_d   = 2'd0;
        state_d = S_PAY;
      end

      S_PAY: begin
        if (target_q == '0) begin
          state_d = S_OFF;
        end else if (pay_hit) begin
          cout_d[pay_idx] = cout_q[pay_idx] + 1'b1;
          inv_d[pay_idx]  = inv_q[pay_idx] - 1'b1;
          target_d        = target_q - denom_val(pay_idx);
          ptr_d           = pay_idx;
          if (target_q == denom_val(pay_idx)) state_d = S_OFF;
        end else if (phase_q == PH_CHANGE) begin
          // Exact change impossible: return paid coins to stock, refund all.
          for (int i = 0; i < 4; i++) begin
            inv_d[i]  = inv_sat_add(inv_q[i], int'(cout_q[i]));
            cout_d[i] = '0;
          end
          target_d = credit_q;
          item_d   = 2'b00;
          phase_d  = PH_REFUND;
          ptr_d    = 2'd0;
        end else begin
          fault_d = 1'b1;
          state_d = S_OFF;
        end
      end

      default: begin
        // OFF lasts one cycle; the return to ON clears the transaction.
        state_d  = S_ON;
        credit_d = '0;
        target_d = '0;
        item_d   = 2'b00;
        fault_d  = 1'b0;
        for (int i = 0; i < 4; i++) cout_d[i] = '0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_ON;
      phase_q  <= PH_CHANGE;
      credit_q <= '0;
      target_q <= '0;
      item_q   <= 2'b00;
      ptr_q    <= 2'd0;
      reject_q <= 1'b0;
      fault_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        inv_q[i]  <= CNT_W'(INIT_CNT);
        cout_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      credit_q <= credit_d;
      target_q <= target_d;
      item_q   <= item_d;
      ptr_q    <= ptr_d;
      reject_q <= reject_d;
      fault_q  <= fault_d;
      for (int i = 0; i < 4; i++) begin
        inv_q[i]  <= inv_d[i];
        cout_q[i] <= cout_d[i];
      end
    end
  end

  assign vif.coin_out_50  = cout_q[0];
  assign vif.coin_out_10  = cout_q[1];
  assign vif.coin_out_5   = cout_q[2];
  assign vif.coin_out_1   = cout_q[3];
  assign vif.item_out     = item_q;
  assign vif.credit       = credit_q;
  assign vif.done         = (state_q == S_OFF);
  assign vif.coin_reject  = reject_q;
  assign vif.short_fault  = fault_q;
  assign vif.service_type = (state_q == S_ON)  ? 2'b01 :
                            (state_q == S_OFF) ? 2'b00 : 2'b10;

`ifdef VEND_SALES_CNT_EN
  logic [15:0] sales_q, sales_d;

  // Add the price of every dispensed item during the OFF cycle; wraps at 2^16.
  always_comb begin
    sales_d = sales_q;
    if (state_q == S_OFF && item_q != 2'b00) sales_d = sales_q + 16'(item_cost(item_q));
  end

  // Sales total register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sales_q <= '0;
    else        sales_q <= sales_d;
  end

  assign vif.sales_total = sales_q;
`endif

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param: vend expectations are queued
// when a request or cancel is issued and checked when done pulses.
module tb_vending_machine_param;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  vending_machine_param_if #(.OUT_W(3), .VAL_W(8)) vif ();

  vending_machine_param dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    item;
    int    c50;
    int    c10;
    int    c5;
    int    c1;
    int    fault;
  } exp_t;

  exp_t sbq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic expect_vend(input string tag, input int item, input int c50,
                             input int c10, input int c5, input int c1, input int fault);
    exp_t e;
    e.tag = tag; e.item = item; e.c50 = c50; e.c10 = c10;
    e.c5 = c5; e.c1 = c1; e.fault = fault;
    sbq.push_back(e);
  endtask

  task automatic deposit(input logic [1:0] n50, input logic [1:0] n10,
                         input logic [1:0] n5, input logic [1:0] n1);
    vif.coin_valid = 1'b1;
    vif.coin_in_50 = n50; vif.coin_in_10 = n10;
    vif.coin_in_5  = n5;  vif.coin_in_1  = n1;
    @(negedge clk);
    vif.coin_valid = 1'b0;
    vif.coin_in_50 = 2'd0; vif.coin_in_10 = 2'd0;
    vif.coin_in_5  = 2'd0; vif.coin_in_1  = 2'd0;
  endtask

  task automatic request(input logic [1:0] item);
    vif.item_req = item;
    @(negedge clk);
    vif.item_req = 2'b00;
  endtask

  task automatic do_cancel();
    vif.cancel = 1'b1;
    @(negedge clk);
    vif.cancel = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // lat counts clock edges from the request/cancel edge to the done cycle.
  task automatic wait_done(output int lat);
    int   n;
    exp_t e;
    n = 1;
    while (vif.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    if (sbq.size() == 0) begin
      chk("scoreboard_nonempty", 32'(sbq.size()), 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk({e.tag, ".done"}, 32'(vif.done), 32'd1);
    if (vif.done !== 1'b1) return;
    chk({e.tag, ".item"},    32'(vif.item_out),     32'(e.item));
    chk({e.tag, ".out50"},   32'(vif.coin_out_50),  32'(e.c50));
    chk({e.tag, ".out10"},   32'(vif.coin_out_10),  32'(e.c10));
    chk({e.tag, ".out5"},    32'(vif.coin_out_5),   32'(e.c5));
    chk({e.tag, ".out1"},    32'(vif.coin_out_1),   32'(e.c1));
    chk({e.tag, ".fault"},   32'(vif.short_fault),  32'(e.fault));
    chk({e.tag, ".svc_off"}, 32'(vif.service_type), 32'd0);
    @(negedge clk);
    chk({e.tag, ".done_clr"},  32'(vif.done),         32'd0);
    chk({e.tag, ".svc_on"},    32'(vif.service_type), 32'd1);
    chk({e.tag, ".credit0"},   32'(vif.credit),       32'd0);
    chk({e.tag, ".out1_clr"},  32'(vif.coin_out_1),   32'd0);
    chk({e.tag, ".fault_clr"}, 32'(vif.short_fault),  32'd0);
    chk({e.tag, ".item_clr"},  32'(vif.item_out),     32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    reset = 1'b0;
    vif.coin_valid = 1'b0;
    vif.coin_in_50 = 2'd0; vif.coin_in_10 = 2'd0;
    vif.coin_in_5  = 2'd0; vif.coin_in_1  = 2'd0;
    vif.item_req = 2'b00;
    vif.cancel   = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst.svc",    32'(vif.service_type), 32'd1);
    chk("rst.credit", 32'(vif.credit),       32'd0);
    chk("rst.done",   32'(vif.done),         32'd0);
    chk("rst.reject", 32'(vif.coin_reject),  32'd0);
    chk("rst.fault",  32'(vif.short_fault),  32'd0);
    chk("rst.item",   32'(vif.item_out),     32'd0);
    chk("rst.out50",  32'(vif.coin_out_50),  32'd0);
    chk("rst.out1",   32'(vif.coin_out_1),   32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 2x10, item A: change 12 = 10 + 1 + 1, three payouts.
    deposit(2'd0, 2'd2, 2'd0, 2'd0);
    chk("t1.credit", 32'(vif.credit), 32'd20);
    expect_vend("t1", 1, 0, 1, 0, 2, 0);
    request(2'b01);
    wait_done(lat);
    chk("t1.latency", 32'(lat), 32'd5);

    // Stock now 50:2 10:3 5:2 1:0. Build 200, overflow deposit rejected,
    // item B: change 185 = 3x50 + 3x10 + 1x5.
    deposit(2'd3, 2'd0, 2'd0, 2'd0);
    deposit(2'd1, 2'd0, 2'd0, 2'd0);
    chk("t4.credit200", 32'(vif.credit), 32'd200);
    deposit(2'd3, 2'd0, 2'd0, 2'd0);
    chk("t4.reject", 32'(vif.coin_reject), 32'd1);
    chk("t4.credit_hold", 32'(vif.credit), 32'd200);
    @(negedge clk);
    chk("t4.reject_pulse", 32'(vif.coin_reject), 32'd0);
    expect_vend("t4", 2, 3, 3, 1, 0, 0);
    request(2'b10);
    wait_done(lat);

    // Credit 1 below price of A: refund of the single coin.
    deposit(2'd0, 2'd0, 2'd0, 2'd1);
    expect_vend("t4r", 0, 0, 0, 0, 1, 0);
    request(2'b01);
    wait_done(lat);
`ifdef VEND_SALES_CNT_EN
    chk("sales.total", 32'(vif.sales_total), 32'd23);
`endif

    // 1x50, item C: change 28 pays 10,10,5,1,1 then runs out; refund 50.
    do_reset();
    deposit(2'd1, 2'd0, 2'd0, 2'd0);
    expect_vend("t2", 0, 1, 0, 0, 0, 0);
    request(2'b11);
    wait_done(lat);

    // 1x5 then 2x1, cancel: refund 7.
    do_reset();
    deposit(2'd0, 2'd0, 2'd1, 2'd0);
    deposit(2'd0, 2'd0, 2'd0, 2'd2);
    chk("t3.credit", 32'(vif.credit), 32'd7);
    expect_vend("t3", 0, 0, 0, 1, 2, 0);
    do_cancel();
    wait_done(lat);

    // Reset pulled low while paying: outputs return asynchronously.
    do_reset();
    deposit(2'd0, 2'd0, 2'd0, 2'd1);
    request(2'b11);
    @(negedge clk);
    chk("t5.busy", 32'(vif.service_type), 32'd2);
    chk("t5.credit_busy", 32'(vif.credit), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5.svc", 32'(vif.service_type), 32'd1);
    chk("t5.credit", 32'(vif.credit), 32'd0);
    chk("t5.done", 32'(vif.done), 32'd0);
    chk("t5.out1", 32'(vif.coin_out_1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Zero-credit cancel is ignored.
    do_cancel();
    chk("t6.cancel0_svc", 32'(vif.service_type), 32'd1);
    chk("t6.cancel0_done", 32'(vif.done), 32'd0);

    // Repeated 9-credit refunds drain the 5s; the third refund hits the
    // 1-coin output limit of 7 and raises short_fault.
    for (int r = 0; r < 3; r++) begin
      repeat (3) deposit(2'd0, 2'd0, 2'd0, 2'd3);
      chk("t6.credit", 32'(vif.credit), 32'd9);
      if (r < 2) expect_vend("t6.refund", 0, 0, 0, 1, 4, 0);
      else       expect_vend("t6.short", 0, 0, 0, 0, 7, 1);
      do_cancel();
      wait_done(lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
